usb_fs_tx_arbiter: RTL and testbench

Shares the single USB full-speed serial transmitter between NUM_REQ packet sources, such as the IN endpoint data engine and the OUT endpoint handshake engine. It selects a requester by round-robin and issues the transmitter's one-cycle packet start with the winner's PID. It routes the winner's byte stream to the transmitter and holds the grant until the transmitter signals end of packet. Before the next grant it enforces a minimum inter-packet gap, counted in bit strobes.

---
 rtl/usb_fs_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_usb_fs_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_tx_arbiter.sv
// usb_fs_tx_arbiter
// Shares one USB full-speed serial transmitter between NUM_REQ packet sources.
// A requester is picked round-robin in IDLE. The next cycle issues a one-cycle
// tx_pkt_start with the winner's PID. The winner's byte stream is routed to the
// transmitter until tx_pkt_end. A gap of GAP_BITS bit strobes must then pass
// before the next grant.
//
// Optional feature: define USB_TX_ARB_FIXED_PRIO_EN to make the lowest set
// request index always win, so handshakes can pre-empt queued data. The
// round-robin pointer is then not kept.
//
// Ports:
//   clk_48mhz, reset_n        clock, asynchronous active-low reset
//   bit_strobe                12 MHz bit-time strobe (gap timing)
//   req, req_pid              per-requester level request and PID
//   req_data_avail, req_data  per-requester payload stream
//   req_data_get              byte-consumed pulse, owner only
//   grant                     one-hot owner (zero when none)
//   req_done                  one-cycle pulse to owner when its packet ends
//   busy                      high from grant through end of gap
//   tx_pkt_start, tx_pid      packet start pulse and PID to transmitter
//   tx_data_avail, tx_data    routed byte stream to transmitter
//   tx_data_get, tx_pkt_end   from transmitter
module usb_fs_tx_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int GAP_BITS = 4
) (
    input  logic                   clk_48mhz,
    input  logic                   reset_n,
    input  logic                   bit_strobe,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_pid,
    input  logic [NUM_REQ-1:0]     req_data_avail,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_data_get,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic                   busy,
    output logic                   tx_pkt_start,
    output logic [3:0]             tx_pid,
    output logic                   tx_data_avail,
    output logic [7:0]             tx_data,
    input  logic                   tx_data_get,
    input  logic                   tx_pkt_end
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_e;

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 busy_q;
    logic                 start_q;
    logic [3:0]           pid_q;
    logic [3:0]           gap_q;

    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;
    logic [3:0]           win_pid;
    logic [NUM_REQ-1:0]   win_oh;

`ifndef USB_TX_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [PTR_W-1:0]     owner_q;
    logic [PTR_W:0]       scan_sum;
`endif
    logic [PTR_W-1:0]     scan;

    // Winner search: first set request at or after the pointer, wrapping.
    // In fixed-priority builds the scan simply starts at index 0.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
`ifndef USB_TX_ARB_FIXED_PRIO_EN
        scan_sum = '0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef USB_TX_ARB_FIXED_PRIO_EN
            scan = PTR_W'(k);
`else
            // ptr < NUM_REQ and k < NUM_REQ, so one subtraction wraps it
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            scan = scan_sum[PTR_W-1:0];
`endif
            if (!win_vld && req[scan]) begin
                win_vld = 1'b1;
                win_idx = scan;
            end
        end
    end

    always_comb begin
        win_pid = 4'h0;
        win_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_pid   = req_pid[4*i +: 4];
                win_oh[i] = 1'b1;
            end
        end
    end

`ifndef USB_TX_ARB_FIXED_PRIO_EN
    assign ptr_d = (owner_q == PTR_W'(NUM_REQ-1)) ? '0 : owner_q + PTR_W'(1);
`endif

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            pid_q   <= 4'h0;
            gap_q   <= 4'h0;
`ifndef USB_TX_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
            owner_q <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        grant_q <= win_oh;
                        pid_q   <= win_pid;
                        busy_q  <= 1'b1;
`ifndef USB_TX_ARB_FIXED_PRIO_EN
                        owner_q <= win_idx;
`endif
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    // Registered, so the pulse is seen the cycle after grant
                    start_q <= 1'b1;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    if (tx_pkt_end) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        gap_q   <= 4'h0;
`ifndef USB_TX_ARB_FIXED_PRIO_EN
                        ptr_q   <= ptr_d;
`endif
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Compare before counting: GAP_BITS=0 exits next cycle
                    if (gap_q == 4'(GAP_BITS)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (bit_strobe) begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Byte stream routing follows the one-hot grant; zero when nobody owns it
    always_comb begin
        tx_data_avail = 1'b0;
        tx_data       = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                tx_data_avail = req_data_avail[i];
                tx_data       = req_data[8*i +: 8];
            end
        end
    end

    assign req_data_get = {NUM_REQ{tx_data_get}} & grant_q;
    assign grant        = grant_q;
    assign req_done     = done_q;
    assign busy         = busy_q;
    assign tx_pkt_start = start_q;
    assign tx_pid       = pid_q;

endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// Testbench for usb_fs_tx_arbiter: randomized packets from the requesters.
// The stimulus side pushes expected starts, done pulses and routed bytes into
// queues. A negedge monitor pops them and compares them with the DUT outputs.
module tb_usb_fs_tx_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int GAP_BITS = 4;

    logic                   clk_48mhz;
    logic                   reset_n;
    logic                   bit_strobe;
    logic [NUM_REQ-1:0]     req;
    logic [4*NUM_REQ-1:0]   req_pid;
    logic [NUM_REQ-1:0]     req_data_avail;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_data_get;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     req_done;
    logic                   busy;
    logic                   tx_pkt_start;
    logic [3:0]             tx_pid;
    logic                   tx_data_avail;
    logic [7:0]             tx_data;
    logic                   tx_data_get;
    logic                   tx_pkt_end;

    usb_fs_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_BITS(GAP_BITS)) dut (
        .clk_48mhz      (clk_48mhz),
        .reset_n        (reset_n),
        .bit_strobe     (bit_strobe),
        .req            (req),
        .req_pid        (req_pid),
        .req_data_avail (req_data_avail),
        .req_data       (req_data),
        .req_data_get   (req_data_get),
        .grant          (grant),
        .req_done       (req_done),
        .busy           (busy),
        .tx_pkt_start   (tx_pkt_start),
        .tx_pid         (tx_pid),
        .tx_data_avail  (tx_data_avail),
        .tx_data        (tx_data),
        .tx_data_get    (tx_data_get),
        .tx_pkt_end     (tx_pkt_end)
    );

    initial clk_48mhz = 1'b0;
    always #5 clk_48mhz = ~clk_48mhz;

    // Bit strobe: one cycle high out of every four
    initial begin
        bit_strobe = 1'b0;
        forever begin
            repeat (3) @(posedge clk_48mhz);
            #1 bit_strobe = 1'b1;
            @(posedge clk_48mhz);
            #1 bit_strobe = 1'b0;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model and scoreboard queues ----------------
    int                 m_ptr;
    int                 st_idx_q[$];
    logic [3:0]         st_pid_q[$];
    logic [NUM_REQ-1:0] done_exp_q[$];
    logic [7:0]         d_byte_q[$];
    logic               d_avail_q[$];
    logic [NUM_REQ-1:0] d_get_q[$];

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    function automatic logic bit_of(input logic [NUM_REQ-1:0] v, input int i);
        logic [NUM_REQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [3:0] pid_of(input int i);
        logic [4*NUM_REQ-1:0] t;
        t = req_pid >> (4*i);
        return t[3:0];
    endfunction

    function automatic logic [7:0] byte_of(input int i);
        logic [8*NUM_REQ-1:0] t;
        t = req_data >> (8*i);
        return t[7:0];
    endfunction

    // Arbitration rule: first pending request scanning upward from base, wrapping
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
        int base;
        base = p;
`ifdef USB_TX_ARB_FIXED_PRIO_EN
        base = 0;
`endif
        for (int k = 0; k < NUM_REQ; k++)
            if (bit_of(r, (base + k) % NUM_REQ)) return (base + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic set_pid(input int i, input logic [3:0] p);
        logic [4*NUM_REQ-1:0] m;
        m = (4*NUM_REQ)'(4'hF) << (4*i);
        req_pid = (req_pid & ~m) | (((4*NUM_REQ)'(p)) << (4*i));
    endtask

    task automatic raise_random(input int excl);
        logic [NUM_REQ-1:0] m;
        m = NUM_REQ'($urandom) & ~oh(excl);
        for (int i = 0; i < NUM_REQ; i++)
            if (bit_of(m, i) && !bit_of(req, i)) set_pid(i, 4'($urandom));
        req = req | m;
    endtask

    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    // One packet from arbitration to req_done, plus ignored events in the gap
    task automatic do_packet(input int nbytes, input bit drop, input bit early_end, input bit keep);
        int w;
        int t;
        w = pick(req, m_ptr);
        if (w < 0) begin
            check("no_pending_request", 0, 1);
            return;
        end
        st_idx_q.push_back(w);
        st_pid_q.push_back(pid_of(w));
        t = 0;
        while (grant == '0 && t < 300) begin
            tick();
            t++;
        end
        if (grant == '0) begin
            check("grant_timeout", 0, 1);
            return;
        end
        // This cycle is START: an end here must be ignored
        if (early_end) tx_pkt_end = 1'b1;
        tick();
        tx_pkt_end = 1'b0;
        if (drop) req = req & ~oh(w);
        for (int b = 0; b < nbytes; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            req_data       = (8*NUM_REQ)'({$urandom, $urandom});
            req_data_avail = NUM_REQ'($urandom);
            d_byte_q.push_back(byte_of(w));
            d_avail_q.push_back(bit_of(req_data_avail, w));
            d_get_q.push_back(oh(w));
            tx_data_get = 1'b1;
            tick();
            tx_data_get = 1'b0;
        end
        if ($urandom_range(0, 1) == 1) raise_random(w);
        tx_pkt_end = 1'b1;
        done_exp_q.push_back(oh(w));
`ifndef USB_TX_ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % NUM_REQ;
`endif
        // Sometimes a new request lands in the same cycle as the end
        if ($urandom_range(0, 2) == 0) raise_random(w);
        tick();
        tx_pkt_end = 1'b0;
        // req_done now visible; the requester withdraws or queues another packet
        req = req & ~oh(w);
        if (keep || $urandom_range(0, 1) == 1) begin
            set_pid(w, 4'($urandom));
            req = req | oh(w);
        end
        if (req == '0) raise_random(NUM_REQ);
        if (req == '0) req = oh($urandom_range(0, NUM_REQ - 1));
        if (GAP_BITS >= 2) begin
            tx_pkt_end = 1'b1;
            tick();
            tx_pkt_end = 1'b0;
            d_byte_q.push_back(8'h00);
            d_avail_q.push_back(1'b0);
            d_get_q.push_back('0);
            tx_data_get = 1'b1;
            tick();
            tx_data_get = 1'b0;
        end
    endtask

    // ---------------- monitor ----------------
    logic [NUM_REQ-1:0] prev_grant;
    logic [NUM_REQ-1:0] prev_req;
    logic               prev_busy;
    logic               mon_vld;
    logic               counting;
    int                 sc;
    int                 sc_lag;

    always @(negedge clk_48mhz) begin
        if (!reset_n) begin
            mon_vld  = 1'b0;
            counting = 1'b0;
            sc       = 0;
            sc_lag   = 0;
        end else begin
            if (tx_pkt_start) begin
                if (st_idx_q.size() == 0) begin
                    check("unexpected_pkt_start", 1, 0);
                end else begin
                    int         ei;
                    logic [3:0] ep;
                    ei = st_idx_q.pop_front();
                    ep = st_pid_q.pop_front();
                    check("start_grant", grant, oh(ei));
                    check("start_pid", tx_pid, ep);
                    check("start_busy", busy, 1);
                    if (mon_vld) check("grant_before_start", prev_grant, grant);
                end
            end
            if (req_done != '0) begin
                if (done_exp_q.size() == 0) check("unexpected_req_done", req_done, 0);
                else check("req_done", req_done, done_exp_q.pop_front());
                check("grant_clear_at_done", grant, 0);
            end
            if (mon_vld && prev_busy && !busy && counting) begin
                check("gap_strobes", sc_lag, GAP_BITS);
                counting = 1'b0;
            end
            if (req_done != '0) begin
                counting = 1'b1;
                sc_lag   = 0;
                sc       = int'(bit_strobe);
            end else begin
                sc_lag = sc;
                sc     = sc + int'(bit_strobe);
            end
            // Idle with a pending request must grant on the very next edge
            if (mon_vld && !prev_busy) check("idle_grant", |grant, |prev_req);
            if (tx_data_get) begin
                if (d_byte_q.size() == 0) begin
                    check("unexpected_data_get", 1, 0);
                end else begin
                    check("tx_data", tx_data, d_byte_q.pop_front());
                    check("tx_data_avail", tx_data_avail, d_avail_q.pop_front());
                    check("req_data_get", req_data_get, d_get_q.pop_front());
                end
            end else begin
                check("req_data_get_idle", req_data_get, 0);
            end
            prev_grant = grant;
            prev_req   = req;
            prev_busy  = busy;
            mon_vld    = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        reset_n        = 1'b0;
        req            = '0;
        req_pid        = (4*NUM_REQ)'({$urandom, $urandom});
        req_data_avail = '0;
        req_data       = '0;
        tx_data_get    = 1'b0;
        tx_pkt_end     = 1'b0;
        m_ptr          = 0;
        repeat (3) @(posedge clk_48mhz);
        #1 reset_n = 1'b1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_start", tx_pkt_start, 0);
        check("rst_pid", tx_pid, 0);
        check("rst_done", req_done, 0);
        repeat (3) tick();

        // Single request with PID 0010
        set_pid(0, 4'b0010);
        req = 2'b01;
        do_packet(0, 1'b0, 1'b0, 1'b0);
        // Both requesters held high
        req = 2'b11;
        for (int p = 0; p < 4; p++) do_packet(3, 1'b0, 1'b0, 1'b1);
        // Randomized traffic
        for (int p = 0; p < 40; p++)
            do_packet($urandom_range(0, 4), $urandom_range(0, 5) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

        // Let the arbiter go idle, then reset in the middle of a packet
        req = '0;
        t = 0;
        while (busy && t < 300) begin
            tick();
            t++;
        end
        check("idle_before_reset_test", busy, 0);
        set_pid(0, 4'($urandom));
        req = 2'b01;
        st_idx_q.push_back(pick(req, m_ptr));
        st_pid_q.push_back(pid_of(pick(req, m_ptr)));
        t = 0;
        while (grant == '0 && t < 300) begin
            tick();
            t++;
        end
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_grant", grant, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_start", tx_pkt_start, 0);
        check("async_rst_pid", tx_pid, 0);
        m_ptr = 0;
        req = 2'b11;
        set_pid(0, 4'($urandom));
        set_pid(1, 4'($urandom));
        tick();
        reset_n = 1'b1;
        do_packet(2, 1'b0, 1'b0, 1'b0);
        req = '0;
        repeat (60) tick();
        check("leftover_starts", st_idx_q.size(), 0);
        check("leftover_dones", done_exp_q.size(), 0);
        check("leftover_bytes", d_byte_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
